// File: rtl/ram_burst_writer_pkg.sv
// ram_burst_writer shared types and defaults.
// FSM encoding and default widths for the burst writer slice.
package ram_writer_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_burst_writer_if.sv
// Byte stream valid/ready handshake into the burst writer.
// master drives data/valid, slave answers with ready.
interface ram_burst_writer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/ram_burst_writer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-before-write on collision; the array itself is never reset.
module sdp_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd <= '0;
    else        rd <= mem[ra];
  end

endmodule

// File: rtl/ram_burst_writer.sv
// Burst writer: streams bytes into a 2**ADDR_WIDTH RAM from a base
// address, with a ROM-compatible registered read port.
module ram_burst_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  ram_burst_writer_if.slave     s_if,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  rdy_q;
  logic                  beat;

  assign s_if.in_ready = rdy_q;
  assign beat          = rdy_q & s_if.in_valid;
  assign cnt_nxt       = wr_count + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
      wr_addr  <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_addr  <= base_addr;
            len_q    <= length;
            wr_count <= '0;
            busy     <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WRITE;
              rdy_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (beat) begin
            wr_addr  <= wr_addr + ADDR_WIDTH'(1);
            wr_count <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state <= DONE;
              rdy_q <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sdp_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (beat),
    .wa   (wr_addr),
    .wd   (s_if.in_data),
    .ra   (rd_addr),
    .rd   (rd_data)
  );

endmodule

// File: tb/tb_ram_burst_writer.sv
// Self-checking bench for ram_burst_writer.
// Reference memory image is a plain byte array indexed by (base+i) mod 256.
module tb_ram_burst_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic [8:0] wr_count;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  ram_burst_writer_if #(.DATA_WIDTH(8)) sif ();

  ram_burst_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .s_if     (sif),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model [256];

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [31:0] vpat;
    logic [7:0]  seed;
    int          exp_cyc;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [7:0] e);
    rd_addr = a;
    tick();
    chk($sformatf("rd[%02h]", a), rd_data, e);
  endtask

  // One complete burst; rnd selects random valid/data, poke pulses
  // a stray start at that cycle index.
  task automatic burst(input logic [7:0] base, input logic [8:0] len,
                       input logic [31:0] vpat, input bit rnd,
                       input logic [7:0] seed, input int exp_cyc,
                       input int poke, input logic [8:0] exp_cnt);
    int         beats;
    int         cyc;
    bit         v;
    logic [7:0] d;
    beats = 0;
    cyc   = 0;
    start = 1'b1;
    base_addr = base;
    length = len;
    tick();
    start = 1'b0;
    base_addr = 8'($urandom);
    length = 9'($urandom);
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", sif.in_ready, len != 0);
    while (beats < int'(len) && cyc < 3000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : vpat[cyc % 32];
      d = rnd ? 8'($urandom) : seed + 8'(beats);
      sif.in_valid = v;
      sif.in_data  = v ? d : 8'hEE;
      if (cyc == poke) begin
        start = 1'b1;
        base_addr = 8'h80;
        length = 9'd5;
      end else begin
        start = 1'b0;
      end
      chk("in_ready_write", sif.in_ready, 1);
      chk("wr_count_live", wr_count, beats);
      tick();
      if (v) begin
        model[8'(int'(base) + beats)] = d;
        beats++;
      end
      cyc++;
    end
    start = 1'b0;
    sif.in_valid = 1'b0;
    chk("beats", beats, len);
    if (exp_cyc >= 0) chk("cycles", cyc, exp_cyc);
    chk("done_pulse", done, 1);
    chk("ready_in_done", sif.in_ready, 0);
    chk("busy_in_done", busy, 1);
    chk("wr_count_end", wr_count, exp_cnt);
    tick();
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    logic [7:0] wexp [4];
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    rd_addr = '0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;

    #12;
    chk("rst_ready", sif.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_rd", rd_data, 0);
    #10 rst_n = 1'b1;
    tick();

    // Full-depth random fill so every model entry is known.
    burst(8'($urandom), 9'd256, 0, 1, 0, -1, -1, 9'd256);

    vecs[0] = '{8'h10, 9'd4, 32'hFFFF_FFFF, 8'hA0, 4, 9'd4};
    vecs[1] = '{8'hFE, 9'd4, 32'hFFFF_FFFF, 8'h01, 4, 9'd4};
    vecs[2] = '{8'h40, 9'd3, 32'b101001, 8'h30, 6, 9'd3};
    vecs[3] = '{8'h05, 9'd1, 32'hFFFF_FFFF, 8'h77, 1, 9'd1};
    vecs[4] = '{8'h70, 9'd0, 32'hFFFF_FFFF, 8'h00, 0, 9'd0};
    vecs[5] = '{8'hC8, 9'd5, 32'h155, 8'h10, 9, 9'd5};
    for (int i = 0; i < 6; i++)
      burst(vecs[i].base, vecs[i].len, vecs[i].vpat, 0,
            vecs[i].seed, vecs[i].exp_cyc, -1, vecs[i].exp_cnt);

    for (int i = 0; i < 4; i++)
      rd_expect(8'h10 + 8'(i), 8'hA0 + 8'(i));
    wexp[0] = 8'h01; wexp[1] = 8'h02; wexp[2] = 8'h03; wexp[3] = 8'h04;
    for (int i = 0; i < 4; i++)
      rd_expect(8'hFE + 8'(i), wexp[i]);

    // Stray start mid-burst must not redirect it.
    burst(8'h30, 9'd4, 32'hFFFF_FFFF, 0, 8'h61, 4, 2, 9'd4);

    // Read/write collision returns old contents first.
    burst(8'h20, 9'd1, 32'hFFFF_FFFF, 0, 8'h55, 1, -1, 9'd1);
    start = 1'b1; base_addr = 8'h20; length = 9'd1;
    tick();
    start = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_data = 8'h99;
    rd_addr = 8'h20;
    tick();
    sif.in_valid = 1'b0;
    chk("collide_old", rd_data, 8'h55);
    chk("collide_done", done, 1);
    model[8'h20] = 8'h99;
    tick();
    chk("collide_new", rd_data, 8'h99);
    chk("collide_idle", busy, 0);

    for (int k = 0; k < 8; k++) begin
      logic [8:0] l;
      l = 9'($urandom_range(1, 40));
      burst(8'($urandom), l, 0, 1, 0, -1, -1, l);
    end

    // Reset after three beats of an eight-word burst.
    start = 1'b1; base_addr = 8'h50; length = 9'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = 8'hC0 + 8'(i);
      tick();
      model[8'h50 + 8'(i)] = 8'hC0 + 8'(i);
    end
    sif.in_valid = 1'b0;
    chk("pre_rst_count", wr_count, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", sif.in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", wr_count, 0);
    chk("arst_rd", rd_data, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    rd_expect(8'h51, 8'hC1);
    burst(8'h58, 9'd4, 32'hFFFF_FFFF, 0, 8'hD0, 4, -1, 9'd4);

    for (int a = 0; a < 256; a++)
      rd_expect(8'(a), model[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_writer.md
# ram_burst_writer

Sequential write-side counterpart to the team's 8-bit synchronous single-port ROM. It accepts a byte stream over a valid/ready handshake and writes it into an internal 256×8 memory, starting at a programmable base address. A registered read port with the same one-cycle latency as the ROM lets downstream logic, and the bench, read the image back. It is used to load lookup tables at runtime that were previously fixed in ROM.

## Interface
Parameters:
- ADDR_WIDTH, 8, address width; memory depth is 2**ADDR_WIDTH
- DATA_WIDTH, 8, data word width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse that begins a burst; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first write address; latched on accepted start
- length  in  ADDR_WIDTH+1  number of words in the burst (0..256); latched on accepted start
- in_data  in  DATA_WIDTH  stream data
- in_valid  in  1  in_data is valid
- in_ready  out  1  writer accepts a word this cycle
- busy  out  1  burst in progress (WRITE or DONE state)
- done  out  1  one-cycle pulse at end of burst
- wr_count  out  ADDR_WIDTH+1  words written in current/last burst
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data, one cycle after rd_addr

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE, start=1 and length≠0 -> WRITE. Latch base_addr into wr_addr and length into len_q; clear wr_count.
- IDLE, start=1 and length=0 -> DONE. No writes; wr_count=0.
- WRITE: in_ready=1. Each edge with in_valid & in_ready writes mem[wr_addr]=in_data, then wr_addr+1 (mod 2**ADDR_WIDTH, wraps 255->0) and wr_count+1.
- WRITE -> DONE on the beat where wr_count+1 == len_q.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- start outside IDLE is ignored; it is neither queued nor changes base or length.
- in_valid=0 in WRITE stalls the burst indefinitely; no timeout.
- Read port is independent and active in every state. If a read and a write target the same address in the same cycle, rd_data returns the old contents (read-before-write).
- Reset: state=IDLE, in_ready=0, busy=0, done=0, wr_count=0, rd_data=0, wr_addr=0. Memory contents are not cleared. Reset mid-burst keeps the words already written; the bench must not expect erasure.

## Timing
- start accepted at edge N -> in_ready=1, busy=1 from cycle N+1.
- First word can be written at edge N+1.
- Last beat at edge M -> in_ready=0, done=1 in cycle M+1; busy drops at M+2. Next start is accepted at edge M+2 at the earliest.
- length=0: done=1 in cycle N+1, in_ready never asserts.
- rd_addr sampled at edge K -> rd_data valid after edge K; one-cycle latency, matching the ROM.
- Maximum throughput is one word per cycle; in_ready stays high continuously through WRITE.

## Structure
- Package ram_writer_pkg: ADDR_WIDTH/DATA_WIDTH defaults, FSM state encoding (IDLE=2'd0, WRITE=2'd1, DONE=2'd2).
- Sub-module sdp_ram: simple dual-port memory with one write port and one registered read port, read-before-write, no reset on the array.
- The top level holds the FSM, the address and count registers, and handshake logic.

## Test plan
- Basic burst: base=0x10, length=4, stream 0xA0..0xA3 back-to-back -> in_ready high 4 cycles, done one cycle after the 4th beat, wr_count=4; readback of 0x10..0x13 = A0..A3, each one cycle after rd_addr.
- Wrap-around: base=0xFE, length=4, data 1,2,3,4 -> mem[FE]=1, mem[FF]=2, mem[00]=3, mem[01]=4.
- Stalls: length=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, done after the 6th cycle, no write on gap cycles.
- Zero length and ignored start: length=0 -> done at N+1, no memory change. During a later burst, pulse start with base=0x80 -> burst continues at its original addresses.
- Read/write collision: mem[0x20]=0x55, burst writes 0x99 to 0x20 while rd_addr=0x20 -> rd_data=0x55 next cycle, 0x99 on the following read.
- Reset mid-burst: length=8, assert rst_n=0 after 3 beats -> outputs at reset values immediately (async). First 3 words remain in memory; a new start works normally.
